aer_core_event_dispatcher: RTL and testbench

Receives next-layer AER events from the upstream merger over a 4-phase req/ack link and delivers them to the core array over per-core 4-phase links.
- Neuron events are routed to the single core encoded in the address.
- Timestep events are broadcast to all cores and complete only when every core has acknowledged (barrier).
- Sits at the input of each layer's core array, mirroring the output-side arbiter.

---
 rtl/snn_aer_pkg.sv | 21 ++
 rtl/aer_core_event_dispatcher.sv | 176 +++++++++++++++++
 tb/tb_aer_core_event_dispatcher.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_aer_pkg.sv
// Event-type constants, dispatcher state encoding and core-index helper.
package snn_aer_pkg;

    localparam logic [1:0] EVENT_NEURON   = 2'b00;
    localparam logic [1:0] EVENT_TIMESTEP = 2'b01;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2,
        UP_ACK  = 2'd3
    } disp_state_e;

    // Row-major core numbering: row h, column w.
    function automatic int unsigned core_index(input int unsigned h,
                                               input int unsigned w,
                                               input int unsigned core_w);
        return h * core_w + w;
    endfunction

endpackage

// File: rtl/aer_core_event_dispatcher.sv
// Routes upstream AER events (4-phase) to one core or broadcasts timesteps to all cores (barrier).
// Upstream ack is withheld until every targeted core finishes its own 4-phase handshake.
module aer_core_event_dispatcher
    import snn_aer_pkg::*;
#(
    parameter int CORE_W         = 4,
    parameter int CORE_H         = 4,
    parameter int CORE_NUM       = 16,
    parameter int AER_IN_WIDTH   = 12,
    parameter int AER_CORE_WIDTH = 8,
    parameter int CNT_W          = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      evt_req,
    input  logic [AER_IN_WIDTH-1:0]   evt_addr,
    output logic                      evt_ack,
    output logic [CORE_NUM-1:0]       core_req,
    output logic [AER_CORE_WIDTH-1:0] core_addr,
    input  logic [CORE_NUM-1:0]       core_ack,
    output logic                      busy,
    output logic [CNT_W-1:0]          tstep_cnt,
    output logic [CNT_W-1:0]          drop_cnt
);

    localparam int CW_BITS = $clog2(CORE_W);
    localparam int CH_BITS = $clog2(CORE_H);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Upstream address fields
    logic [1:0]                in_type;
    logic [CH_BITS-1:0]        in_h;
    logic [CW_BITS-1:0]        in_w;
    logic [AER_CORE_WIDTH-1:0] in_caddr;

    assign in_type  = evt_addr[AER_IN_WIDTH-1 -: 2];
    assign in_h     = evt_addr[CW_BITS +: CH_BITS];
    assign in_w     = evt_addr[CW_BITS-1:0];
    assign in_caddr = evt_addr[AER_IN_WIDTH-1 -: AER_CORE_WIDTH];

    // Target decode
    int unsigned         idx;
    logic [CORE_NUM-1:0] route_mask;
    logic                route_ok;

    always_comb begin
        idx        = core_index(32'(in_h), 32'(in_w), CORE_W);
        route_mask = '0;
        route_ok   = 1'b0;
        case (in_type)
            EVENT_NEURON: begin
                if (32'(in_h) < 32'(CORE_H)) begin
                    route_ok = 1'b1;
                    for (int unsigned i = 0; i < CORE_NUM; i++) begin
                        route_mask[i] = (i == idx);
                    end
                end
            end
            EVENT_TIMESTEP: begin
                route_ok   = 1'b1;
                route_mask = '1;
            end
            default: begin
                route_ok = 1'b0;
            end
        endcase
    end

    disp_state_e               state_q,     state_d;
    logic [CORE_NUM-1:0]       mask_q,      mask_d;
    logic [CORE_NUM-1:0]       core_req_q,  core_req_d;
    logic [AER_CORE_WIDTH-1:0] core_addr_q, core_addr_d;
    logic                      is_tstep_q,  is_tstep_d;
    logic                      evt_ack_q,   evt_ack_d;
    logic                      busy_q,      busy_d;
    logic [CNT_W-1:0]          tstep_cnt_q, tstep_cnt_d;
    logic [CNT_W-1:0]          drop_cnt_q,  drop_cnt_d;
    logic                      load_req;
    logic                      in_send;

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        core_addr_d = core_addr_q;
        is_tstep_d  = is_tstep_q;
        evt_ack_d   = evt_ack_q;
        tstep_cnt_d = tstep_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        load_req    = 1'b0;

        case (state_q)
            IDLE: begin
                if (evt_req && !evt_ack_q) begin
                    core_addr_d = in_caddr;
                    is_tstep_d  = (in_type == EVENT_TIMESTEP);
                    if (route_ok) begin
                        mask_d   = route_mask;
                        load_req = 1'b1;
                        state_d  = SEND;
                    end else begin
                        mask_d     = '0;
                        drop_cnt_d = drop_cnt_q + CNT_ONE;
                        evt_ack_d  = 1'b1;
                        state_d    = UP_ACK;
                    end
                end
            end
            SEND: begin
                if (core_req_q == '0) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                // Barrier: only acks of targeted cores can hold us here.
                if ((core_ack & mask_q) == '0) begin
                    evt_ack_d = 1'b1;
                    if (is_tstep_q) begin
                        tstep_cnt_d = tstep_cnt_q + CNT_ONE;
                    end
                    state_d = UP_ACK;
                end
            end
            UP_ACK: begin
                if (!evt_req) begin
                    evt_ack_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Per-core request tracking: each bit drops independently on its own ack.
    assign in_send = (state_q == SEND);

    for (genvar g = 0; g < CORE_NUM; g++) begin : g_core_req
        assign core_req_d[g] = load_req ? route_mask[g]
                                        : (core_req_q[g] & ~(in_send & core_ack[g]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            core_req_q  <= '0;
            core_addr_q <= '0;
            is_tstep_q  <= 1'b0;
            evt_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
            tstep_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            core_req_q  <= core_req_d;
            core_addr_q <= core_addr_d;
            is_tstep_q  <= is_tstep_d;
            evt_ack_q   <= evt_ack_d;
            busy_q      <= busy_d;
            tstep_cnt_q <= tstep_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign evt_ack   = evt_ack_q;
    assign core_req  = core_req_q;
    assign core_addr = core_addr_q;
    assign busy      = busy_q;
    assign tstep_cnt = tstep_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_aer_core_event_dispatcher.sv
// Scoreboard bench: upstream driver queues expected deliveries, core models ack, a monitor checks.
module tb_aer_core_event_dispatcher;

    localparam int NC = 16;

    logic          clk;
    logic          rst;
    logic          evt_req;
    logic [11:0]   evt_addr;
    logic          evt_ack;
    logic [NC-1:0] core_req;
    logic [7:0]    core_addr;
    logic [NC-1:0] core_ack;
    logic          busy;
    logic [15:0]   tstep_cnt;
    logic [15:0]   drop_cnt;

    logic [NC-1:0] model_ack;
    logic [NC-1:0] spurious;
    assign core_ack = model_ack | spurious;

    aer_core_event_dispatcher dut (
        .clk       (clk),
        .rst       (rst),
        .evt_req   (evt_req),
        .evt_addr  (evt_addr),
        .evt_ack   (evt_ack),
        .core_req  (core_req),
        .core_addr (core_addr),
        .core_ack  (core_ack),
        .busy      (busy),
        .tstep_cnt (tstep_cnt),
        .drop_cnt  (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [NC-1:0] mask;
        logic [7:0]    caddr;
        int            kind;   // 0 neuron, 1 timestep, 2 dropped
        int            issue;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   exp_tstep = 0;
    int   exp_drop  = 0;
    int   ack_dly[NC];
    int   rel_dly   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: what the spec says an upstream address should do.
    function automatic exp_t model(input logic [11:0] a);
        exp_t e;
        int t, h, w;
        t = int'(a) >> 10;
        h = (int'(a) >> 2) & 3;
        w = int'(a) & 3;
        e.caddr = 8'(int'(a) >> 4);
        e.issue = 0;
        if (t == 0 && h < 4) begin
            e.kind = 0;
            e.mask = NC'(1) << (h * 4 + w);
        end else if (t == 1) begin
            e.kind = 1;
            e.mask = '1;
        end else begin
            e.kind = 2;
            e.mask = '0;
        end
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Core models: ack after ack_dly[i] cycles of req, drop after rel_dly cycles of req low.
    initial begin
        int cnt[NC];
        model_ack = '0;
        for (int i = 0; i < NC; i++) cnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NC; i++) begin
                if (rst) begin
                    model_ack[i] = 1'b0;
                    cnt[i] = 0;
                end else if (core_req[i] && !model_ack[i]) begin
                    if (cnt[i] >= ack_dly[i]) begin
                        model_ack[i] = 1'b1;
                        cnt[i] = 0;
                    end else cnt[i]++;
                end else if (!core_req[i] && model_ack[i]) begin
                    if (cnt[i] >= rel_dly) begin
                        model_ack[i] = 1'b0;
                        cnt[i] = 0;
                    end else cnt[i]++;
                end else cnt[i] = 0;
            end
        end
    end

    // Monitor
    initial begin
        logic [NC-1:0] prev_req, delivered, rises;
        logic [7:0]    prev_addr;
        logic          prev_ack;
        exp_t          e;
        prev_req = '0; delivered = '0; prev_addr = '0; prev_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_req = '0; delivered = '0; prev_ack = 1'b0;
            end else begin
                rises = core_req & ~prev_req;
                if (rises != '0) begin
                    if (exp_q.size() == 0) begin
                        chk("req_unexpected", 32'(rises), 32'd0);
                    end else begin
                        chk("req_mask", 32'(rises), 32'(exp_q[0].mask));
                        chk("req_latency", 32'(cyc - exp_q[0].issue), 32'd1);
                        chk("core_addr", 32'(core_addr), 32'(exp_q[0].caddr));
                        chk("dup_delivery", 32'(rises & delivered), 32'd0);
                        delivered |= rises;
                    end
                end
                if (core_req != '0) begin
                    chk("busy_during_send", 32'(busy), 32'd1);
                    chk("ack_before_barrier", 32'(evt_ack), 32'd0);
                    if (prev_req != '0) chk("addr_stable", 32'(core_addr), 32'(prev_addr));
                end
                if (evt_ack && !prev_ack) begin
                    if (exp_q.size() == 0) begin
                        chk("ack_unexpected", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind == 1) exp_tstep++;
                        if (e.kind == 2) exp_drop++;
                        chk("delivered", 32'(delivered), 32'(e.mask));
                        chk("barrier_req", 32'(core_req), 32'd0);
                        chk("barrier_ack", 32'(core_ack & e.mask), 32'd0);
                        chk("tstep_cnt", 32'(tstep_cnt), 32'(exp_tstep));
                        chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
                        chk("ack_with_req", 32'(evt_req), 32'd1);
                        if (e.kind == 2) chk("drop_latency", 32'(cyc - e.issue), 32'd1);
                        delivered = '0;
                    end
                end
                prev_req  = core_req;
                prev_ack  = evt_ack;
                prev_addr = core_addr;
            end
        end
    end

    task automatic send_event(input logic [11:0] a, input int hold);
        exp_t e;
        int   n;
        n = 0;
        while (evt_ack && n < 200) begin
            @(negedge clk);
            n++;
        end
        e = model(a);
        e.issue = cyc;
        exp_q.push_back(e);
        evt_req  = 1'b1;
        evt_addr = a;
        @(negedge clk);
        evt_addr = 12'($urandom);  // already sampled; must not matter any more
        n = 0;
        while (!evt_ack && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("evt_ack_timeout", 32'(evt_ack), 32'd1);
        repeat (hold) @(negedge clk);
        evt_req = 1'b0;
        n = 0;
        while (evt_ack && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("evt_ack_release_timeout", 32'(evt_ack), 32'd0);
    endtask

    task automatic set_dly(input int lo, input int hi);
        for (int i = 0; i < NC; i++) ack_dly[i] = $urandom_range(hi, lo);
        rel_dly = $urandom_range(2, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        rst = 1'b1; evt_req = 1'b0; evt_addr = '0; spurious = '0;
        for (int i = 0; i < NC; i++) ack_dly[i] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_evt_ack", 32'(evt_ack), 32'd0);
        chk("rst_core_req", 32'(core_req), 32'd0);
        chk("rst_core_addr", 32'(core_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tstep", 32'(tstep_cnt), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);

        // Neuron route to core 6, with a stray ack on core 0 that must be ignored.
        ack_dly[6] = 2;
        spurious   = 16'h0001;
        send_event(12'h156, 1);
        spurious   = '0;

        // Timestep barrier, cores ack 15..0 one per cycle.
        for (int i = 0; i < NC; i++) ack_dly[i] = 15 - i;
        send_event(12'h400, 0);

        // Straggler core 9.
        for (int i = 0; i < NC; i++) ack_dly[i] = 0;
        ack_dly[9] = 50;
        send_event(12'h4A5, 2);

        // Reserved types.
        send_event(12'hC00, 0);
        send_event(12'h8F3, 1);

        // Back-to-back alternating core 0 / core 15.
        set_dly(0, 1);
        for (int k = 0; k < 8; k++) send_event((k % 2 == 0) ? 12'h2A0 : 12'h13F, 0);

        // Random mix.
        for (int k = 0; k < 40; k++) begin
            logic [1:0] t;
            n = $urandom_range(9, 0);
            t = (n < 6) ? 2'b00 : (n < 8) ? 2'b01 : 2'(n - 6);
            set_dly(0, 4);
            send_event({t, 6'($urandom), 4'($urandom)}, $urandom_range(2, 0));
        end

        // Reset in the middle of a broadcast.
        for (int i = 0; i < NC; i++) ack_dly[i] = 40;
        @(negedge clk);
        e = model(12'h400);
        e.issue = cyc;
        exp_q.push_back(e);
        evt_req = 1'b1; evt_addr = 12'h400;
        n = 0;
        while (core_req != 16'hFFFF && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_pre_req", 32'(core_req), 32'hFFFF);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_core_req", 32'(core_req), 32'd0);
        chk("rst_mid_evt_ack", 32'(evt_ack), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_tstep", 32'(tstep_cnt), 32'd0);
        chk("rst_mid_drop", 32'(drop_cnt), 32'd0);
        exp_q.delete();
        exp_tstep = 0; exp_drop = 0;
        evt_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_dly(0, 2);
        send_event(12'h156, 0);
        send_event(12'h400, 1);

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("final_tstep", 32'(tstep_cnt), 32'(exp_tstep));
        chk("final_drop", 32'(drop_cnt), 32'(exp_drop));
        chk("final_idle", 32'(busy), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
